// File: rtl/probe_capture_hook.sv
// Active probe hook: latches timestamped per-channel samples and serialises them
// as header / timestamp / data-word packets through a small upstream FIFO.
module probe_capture_hook #(
  parameter int NPROBES   = 4,
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int PROBEBASE = 0
) (
  input  logic                     UCLK,
  input  logic                     URST,
  input  logic [NPROBES*WIDTH-1:0] PROBE_DATA,
  input  logic [NPROBES-1:0]       PROBE_VALID,
  input  logic                     ACK,
  output logic [31:0]              DATAUP,
  output logic                     DATAVALID,
  output logic                     DELAY,
  input  logic                     CMDEN,
  input  logic [18:0]              CMD,
  input  logic                     CTIMER
);
  localparam int W  = (WIDTH + 31) / 32;
  localparam int CW = (NPROBES > 1) ? $clog2(NPROBES) : 1;
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STAMP = 2'd1, S_DATA = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cur_q, cur_d, ptr_q, ptr_d;
  logic [WW-1:0]      word_q, word_d;
  logic [31:0]        ts_q, ts_d;
  logic [NPROBES-1:0] en_q, en_d, shot_q, shot_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [NPROBES-1:0] load_s;
  logic [WIDTH-1:0]   hold_data_q [NPROBES];
  logic [31:0]        hold_ts_q [NPROBES];
  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               full_s, pop_s, push_s, hdr_push_s, release_s;
  logic [31:0]        push_word_s;
  logic               gnt_valid_s;
  logic [CW-1:0]      gnt_s;
  logic [CW:0]        sum_s;
  logic [2:0]         op_s;
  logic [31:0]        rel_s;
  logic               cmd_hit_s;
  logic [CW-1:0]      cmd_ch_s;
  logic [W*32-1:0]    pad_s;
  logic [31:0]        words_s [W];
  logic [15:0]        hdr_num_s;

  // Probe numbers below PROBEBASE wrap to huge values and miss the range test.
  assign op_s      = CMD[18:16];
  assign rel_s     = {16'd0, CMD[15:0]} - 32'(PROBEBASE);
  assign cmd_hit_s = (rel_s < 32'(NPROBES));
  assign cmd_ch_s  = rel_s[CW-1:0];

  assign full_s     = (cnt_q == FULL_CNT);
  assign pop_s      = ACK && (cnt_q != '0);
  assign hdr_push_s = push_s && (state_q == S_IDLE);
  assign release_s  = push_s && (state_q == S_DATA) && (word_q == WW'(W - 1));
  assign hdr_num_s  = 16'(PROBEBASE) + {{(16-CW){1'b0}}, gnt_s};

  assign DATAVALID = (cnt_q != '0);
  assign DATAUP    = DATAVALID ? mem_q[rd_q] : 32'd0;
  assign DELAY     = full_s && (|pend_q);

  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_s       = '0;
    sum_s       = '0;
    for (int k = 0; k < NPROBES; k++) begin
      sum_s = {1'b0, ptr_q} + (CW+1)'(k);
      if (sum_s >= (CW+1)'(NPROBES)) sum_s = sum_s - (CW+1)'(NPROBES);
      else sum_s = sum_s;
      if (!gnt_valid_s && pend_q[sum_s[CW-1:0]]) begin
        gnt_valid_s = 1'b1;
        gnt_s       = sum_s[CW-1:0];
      end else begin
        gnt_valid_s = gnt_valid_s;
      end
    end
  end

  always_comb begin
    pad_s = '0;
    pad_s[WIDTH-1:0] = hold_data_q[cur_q];
    for (int w = 0; w < W; w++) words_s[w] = pad_s[w*32 +: 32];
  end

  // Capture uses the enable state from before any same-cycle command.
  always_comb begin
    en_d   = en_q;
    shot_d = shot_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    load_s = '0;
    for (int i = 0; i < NPROBES; i++) begin
      if (hdr_push_s && (gnt_s == CW'(i))) ovf_d[i] = 1'b0;
      else ovf_d[i] = ovf_q[i];
      if (en_q[i] && PROBE_VALID[i]) begin
        if (!pend_q[i] || (release_s && (cur_q == CW'(i)))) begin
          load_s[i] = 1'b1;
          pend_d[i] = 1'b1;
          if (shot_q[i]) begin
            en_d[i]   = 1'b0;
            shot_d[i] = 1'b0;
          end else begin
            en_d[i] = en_q[i];
          end
        end else begin
          ovf_d[i] = 1'b1;
        end
      end else if (release_s && (cur_q == CW'(i))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
    if (CMDEN) begin
      case (op_s)
        3'd0: if (cmd_hit_s) begin en_d[cmd_ch_s] = 1'b0; shot_d[cmd_ch_s] = 1'b0; end else begin end
        3'd1: if (cmd_hit_s) begin en_d[cmd_ch_s] = 1'b1; shot_d[cmd_ch_s] = 1'b0; end else begin end
        3'd2: if (cmd_hit_s) begin en_d[cmd_ch_s] = 1'b1; shot_d[cmd_ch_s] = 1'b1; end else begin end
        3'd3: begin en_d = '1; shot_d = '0; end
        3'd4: begin en_d = '0; shot_d = '0; end
        default: begin end
      endcase
    end else begin
      en_d = en_d;
    end
  end

  always_comb begin
    if (CMDEN && (op_s == 3'd5)) ts_d = 32'd0;
    else if (CTIMER) ts_d = ts_q + 32'd1;
    else ts_d = ts_q;
  end

  always_comb begin
    if (push_s && !pop_s) cnt_d = cnt_q + 1'b1;
    else if (!push_s && pop_s) cnt_d = cnt_q - 1'b1;
    else cnt_d = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s && !full_s) begin
          state_d = S_STAMP;
          cur_d   = gnt_s;
          if (gnt_s == CW'(NPROBES - 1)) ptr_d = '0;
          else ptr_d = gnt_s + 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STAMP: begin
        if (!full_s) begin
          state_d = S_DATA;
          word_d  = '0;
        end else begin
          state_d = S_STAMP;
        end
      end
      S_DATA: begin
        if (!full_s && (word_q == WW'(W - 1))) state_d = S_IDLE;
        else if (!full_s) word_d = word_q + 1'b1;
        else state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_s      = 1'b0;
    push_word_s = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s && !full_s) begin
          push_s      = 1'b1;
          push_word_s = {hdr_num_s, ovf_q[gnt_s], 7'd0, 8'(W)};
        end else begin
          push_s = 1'b0;
        end
      end
      S_STAMP: begin
        push_s      = !full_s;
        push_word_s = hold_ts_q[cur_q];
      end
      S_DATA: begin
        push_s      = !full_s;
        push_word_s = words_s[word_q];
      end
      default: push_s = 1'b0;
    endcase
  end

  always_ff @(posedge UCLK) begin
    if (!URST) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
    end
  end

  always_ff @(posedge UCLK) begin
    if (!URST) begin
      ts_q   <= 32'd0;
      en_q   <= '0;
      shot_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ts_q   <= ts_d;
      en_q   <= en_d;
      shot_q <= shot_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      if (push_s) wr_q <= wr_q + 1'b1;
      if (pop_s) rd_q <= rd_q + 1'b1;
    end
  end

  // Holding data and FIFO storage need no reset: pend_q and cnt_q mark validity.
  always_ff @(posedge UCLK) begin
    for (int i = 0; i < NPROBES; i++) begin
      if (load_s[i]) begin
        hold_data_q[i] <= PROBE_DATA[i*WIDTH +: WIDTH];
        hold_ts_q[i]   <= ts_q;
      end
    end
    if (push_s) mem_q[wr_q] <= push_word_s;
  end

endmodule

// File: tb/tb_probe_capture_hook.sv
// Directed bench for probe_capture_hook: NPROBES=4, WIDTH=40, DEPTH=4, PROBEBASE=8.
module tb_probe_capture_hook;
  localparam int NP = 4;
  localparam int WD = 40;
  localparam int DP = 4;
  localparam int PB = 8;

  logic              UCLK = 1'b0;
  logic              URST = 1'b0;
  logic              ACK = 1'b0;
  logic              CMDEN = 1'b0;
  logic              CTIMER = 1'b0;
  logic [NP*WD-1:0]  PROBE_DATA = '0;
  logic [NP-1:0]     PROBE_VALID = '0;
  logic [18:0]       CMD = '0;
  logic [31:0]       DATAUP;
  logic              DATAVALID;
  logic              DELAY;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int scyc = 0;
  logic [31:0] got_q[$];
  int          got_cyc[$];

  probe_capture_hook #(.NPROBES(NP), .WIDTH(WD), .DEPTH(DP), .PROBEBASE(PB)) dut (
    .UCLK(UCLK), .URST(URST), .PROBE_DATA(PROBE_DATA), .PROBE_VALID(PROBE_VALID),
    .ACK(ACK), .DATAUP(DATAUP), .DATAVALID(DATAVALID), .DELAY(DELAY),
    .CMDEN(CMDEN), .CMD(CMD), .CTIMER(CTIMER)
  );

  always #5 UCLK = ~UCLK;
  always @(posedge UCLK) cyc <= cyc + 1;

  // Collect every word the host consumes, with the cycle it was visible.
  always @(negedge UCLK) begin
    if (URST && ACK && DATAVALID) begin
      got_q.push_back(DATAUP);
      got_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge UCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got(input int i);
    if (i < got_q.size()) return got_q[i];
    else return 32'hxxxx_xxxx;
  endfunction

  task automatic clr();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic cmd(input logic [2:0] op, input logic [15:0] num);
    CMD   = {op, num};
    CMDEN = 1'b1;
    step(1);
    CMDEN = 1'b0;
  endtask

  task automatic send(input int ch, input logic [WD-1:0] data);
    PROBE_DATA[ch*WD +: WD] = data;
    PROBE_VALID[ch] = 1'b1;
    scyc = cyc;
    step(1);
    PROBE_VALID = '0;
  endtask

  task automatic wait_words(input int n, input string tag);
    int budget;
    budget = 80;
    while (got_q.size() < n && budget > 0) begin
      step(1);
      budget--;
    end
    checks++;
    assert (got_q.size() >= n) else begin
      errors++;
      $error("FAIL %s_timeout: observed %0d words expected %0d", tag, got_q.size(), n);
    end
  endtask

  task automatic rr_check(input int first, input string tag);
    int ch;
    for (int j = 0; j < 4; j++) begin
      ch = (first + j) % 4;
      chk($sformatf("%s_hdr%0d", tag, j), got(4*j), {16'(PB + ch), 16'h0002});
      chk($sformatf("%s_dat%0d", tag, j), got(4*j + 2), 32'hD0D0_0000 + 32'(ch));
    end
  endtask

  initial begin
    // Reset defaults
    ACK = 1'b1;
    step(2);
    chk("rst_valid", {31'd0, DATAVALID}, 32'd0);
    chk("rst_dataup", DATAUP, 32'd0);
    chk("rst_delay", {31'd0, DELAY}, 32'd0);
    URST = 1'b1;
    send(0, 40'h01_0000_0001);
    step(6);
    chk("no_enable_quiet", 32'(got_q.size()), 32'd0);

    // Single packet on ch1 (probe 9), timestamp 3
    cmd(3'd1, 16'd9);
    CTIMER = 1'b1;
    step(3);
    CTIMER = 1'b0;
    clr();
    send(1, 40'hAB_1234_5678);
    wait_words(4, "single");
    chk("single_hdr", got(0), 32'h0009_0002);
    chk("single_ts", got(1), 32'h0000_0003);
    chk("single_d0", got(2), 32'h1234_5678);
    chk("single_d1", got(3), 32'h0000_00AB);
    chk("single_latency", 32'(got_cyc[0] - scyc), 32'd2);
    chk("single_back2back", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
    cmd(3'd0, 16'd9);

    // One-shot on ch0: only the first of two samples is sent
    cmd(3'd2, 16'd8);
    clr();
    send(0, 40'h5A_0BAD_F00D);
    step(4);
    send(0, 40'h66_6666_6666);
    wait_words(4, "oneshot");
    step(10);
    chk("oneshot_count", 32'(got_q.size()), 32'd4);
    chk("oneshot_hdr", got(0), 32'h0008_0002);
    chk("oneshot_d0", got(2), 32'h0BAD_F00D);
    chk("oneshot_d1", got(3), 32'h0000_005A);

    // Overflow and backpressure with ACK held low
    cmd(3'd1, 16'd8);
    ACK = 1'b0;
    clr();
    send(0, 40'h11_2222_3333);
    step(4);
    chk("full_no_pend_delay", {31'd0, DELAY}, 32'd0);
    send(0, 40'h44_5555_6666);
    chk("full_pend_delay", {31'd0, DELAY}, 32'd1);
    send(0, 40'h77_8888_9999);
    chk("ovf_delay_hold", {31'd0, DELAY}, 32'd1);
    chk("ovf_head_word", DATAUP, 32'h0008_0002);
    ACK = 1'b1;
    wait_words(8, "ovf");
    step(10);
    chk("ovf_count", 32'(got_q.size()), 32'd8);
    chk("ovf_hdr1", got(0), 32'h0008_0002);
    chk("ovf_d1", got(2), 32'h2222_3333);
    chk("ovf_hdr2", got(4), 32'h0008_8002);
    chk("ovf_ts2", got(5), 32'h0000_0003);
    chk("ovf_d2", got(6), 32'h5555_6666);
    chk("ovf_d2hi", got(7), 32'h0000_0044);
    chk("ovf_delay_clear", {31'd0, DELAY}, 32'd0);

    // Round robin: serve ch3 so the pointer sits at ch0, then all four at once
    cmd(3'd3, 16'd0);
    clr();
    send(3, 40'hC3_D0D0_0003);
    wait_words(4, "rr_pre3");
    chk("rr_pre3_hdr", got(0), 32'h000B_0002);
    clr();
    for (int i = 0; i < NP; i++) PROBE_DATA[i*WD +: WD] = {8'hC0 + 8'(i), 32'hD0D0_0000 + 32'(i)};
    PROBE_VALID = '1;
    step(1);
    PROBE_VALID = '0;
    wait_words(16, "rr_a");
    rr_check(0, "rr_a");
    clr();
    send(1, 40'hC1_D0D0_0001);
    wait_words(4, "rr_pre1");
    clr();
    PROBE_VALID = '1;
    step(1);
    PROBE_VALID = '0;
    wait_words(16, "rr_b");
    rr_check(2, "rr_b");

    // Timestamp clear mid-count
    cmd(3'd4, 16'd0);
    cmd(3'd1, 16'd8);
    CTIMER = 1'b1;
    step(5);
    CTIMER = 1'b0;
    cmd(3'd5, 16'd0);
    CTIMER = 1'b1;
    step(2);
    CTIMER = 1'b0;
    clr();
    send(0, 40'h00_0000_0042);
    wait_words(4, "tsclr");
    chk("tsclr_hdr", got(0), 32'h0008_0002);
    chk("tsclr_ts", got(1), 32'h0000_0002);

    // Out-of-range probe number leaves enables untouched
    cmd(3'd0, 16'h00FF);
    clr();
    send(0, 40'h00_0000_0043);
    wait_words(4, "oor_dis");
    chk("oor_dis_hdr", got(0), 32'h0008_0002);
    cmd(3'd1, 16'h00FF);
    clr();
    send(1, 40'h00_0000_0044);
    step(10);
    chk("oor_en_quiet", 32'(got_q.size()), 32'd0);

    // Timestamp wrap: preload near the top, then tick through FFFFFFFF to 0
    force dut.ts_q = 32'hFFFF_FFFE;
    step(1);
    release dut.ts_q;
    CTIMER = 1'b1;
    step(1);
    CTIMER = 1'b0;
    clr();
    send(0, 40'h00_0000_0045);
    wait_words(4, "wrap_top");
    chk("wrap_top_ts", got(1), 32'hFFFF_FFFF);
    CTIMER = 1'b1;
    step(1);
    CTIMER = 1'b0;
    clr();
    send(0, 40'h00_0000_0046);
    wait_words(4, "wrap_zero");
    chk("wrap_zero_ts", got(1), 32'h0000_0000);

    // Arm and sample in the same cycle: no capture, the next sample is taken
    cmd(3'd4, 16'd0);
    clr();
    CMD = {3'd2, 16'd9};
    CMDEN = 1'b1;
    PROBE_DATA[1*WD +: WD] = 40'h00_0000_0047;
    PROBE_VALID[1] = 1'b1;
    step(1);
    CMDEN = 1'b0;
    PROBE_VALID = '0;
    step(10);
    chk("arm_same_cycle_quiet", 32'(got_q.size()), 32'd0);
    send(1, 40'hE1_0000_0048);
    wait_words(4, "arm_next");
    chk("arm_next_hdr", got(0), 32'h0009_0002);
    chk("arm_next_d0", got(2), 32'h0000_0048);

    // Reset mid-packet discards FIFO contents and enables
    cmd(3'd1, 16'd8);
    ACK = 1'b0;
    send(0, 40'h00_0000_0049);
    step(2);
    chk("midpkt_valid", {31'd0, DATAVALID}, 32'd1);
    URST = 1'b0;
    step(1);
    URST = 1'b1;
    chk("midpkt_rst_valid", {31'd0, DATAVALID}, 32'd0);
    chk("midpkt_rst_dataup", DATAUP, 32'd0);
    ACK = 1'b1;
    clr();
    send(0, 40'h00_0000_004A);
    step(10);
    chk("midpkt_rst_quiet", 32'(got_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/probe_capture_hook.md
# probe_capture_hook

Parametrised probe hook that captures samples from `NPROBES` design probes and packetises them into 32-bit words on the `DATAUP`/`DATAVALID`/`ACK` upstream channel. Probes are enabled, disabled or armed for one-shot capture by host commands on `CMDEN`/`CMD`. Each packet carries a timestamp built from `CTIMER` ticks. Sits beside the user design as the active replacement for the passive probe-hook crumb, and drives the same host-facing signal set.

## Interface
Parameters:
- `NPROBES`, 4: number of probe channels, 1..16
- `WIDTH`, 64: bits per probe sample, 1..256; `W = ceil(WIDTH/32)` data words per packet
- `DEPTH`, 16: upstream FIFO depth in 32-bit words, power of 2, ≥ 4
- `PROBEBASE`, 0: probe number of channel 0; channel i is number `PROBEBASE+i`

Ports:
- `UCLK` in 1: the single clock; all logic is on the rising edge
- `URST` in 1: reset, synchronous, active-low
- `PROBE_DATA` in NPROBES*WIDTH: channel i occupies `[i*WIDTH +: WIDTH]`
- `PROBE_VALID` in NPROBES: per-channel sample strobe
- `ACK` in 1: host consumes the current `DATAUP` word
- `DATAUP` out 32: FIFO head word; 0 when empty
- `DATAVALID` out 1: FIFO not empty
- `DELAY` out 1: stall request to the host/clock controller
- `CMDEN` in 1: command strobe
- `CMD` in 19: `[18:16]` opcode, `[15:0]` probe number
- `CTIMER` in 1: timestamp tick

## Operation
- Timestamp: 32-bit counter; increments on each cycle with `CTIMER=1`; wraps from `FFFFFFFF` to 0.
- Commands, applied at the edge of the cycle where `CMDEN=1`:
  - 0: disable probe
  - 1: enable probe (continuous)
  - 2: arm one-shot; capture next sample, then auto-disable
  - 3: enable all
  - 4: disable all
  - 5: clear timestamp to 0
  - 6–7: no-op
- Probe numbers outside `PROBEBASE..PROBEBASE+NPROBES-1` are ignored for opcodes 0–2.
- Capture: an enabled channel with `PROBE_VALID=1` latches `PROBE_DATA` and the current timestamp into its holding register and sets pending. A holding register may load if it is empty, or if its last word is being pushed this cycle.
- Overflow: if `PROBE_VALID=1` on an enabled channel whose holding register cannot load, the sample is dropped and the channel's sticky overflow bit is set. The bit is reported in, and cleared by, the channel's next header push.
- Disable affects only new captures; a pending sample is still sent.
- Serializer FSM:
  - IDLE: a round-robin arbiter picks a pending channel, starting after the last-served channel. The header is pushed in the same cycle if the FIFO is not full → STAMP.
  - STAMP: push timestamp → DATA.
  - DATA: push data words least-significant word first. Bits above `WIDTH` in the last word are 0. After word W-1, release the holding register → IDLE.
  - Any state: no push and no state advance while the FIFO is full.
- Header word: `[31:16]` probe number, `[15]` overflow, `[14:8]` 0, `[7:0]` W.
- FIFO pop: on `ACK & DATAVALID`. `ACK` while empty is ignored. A push is blocked when count==DEPTH, even if a pop occurs in the same cycle.
- `DELAY`: 1 when FIFO count==DEPTH and at least one channel is pending.

## Timing
- Reset (`URST=0` at an edge): all channels disabled, holding registers empty, overflow bits clear, timestamp 0, FSM IDLE, arbiter pointer at channel 0, FIFO empty. Outputs: `DATAUP=0`, `DATAVALID=0`, `DELAY=0`. Reset mid-packet discards the partial packet and all FIFO contents.
- Latency: sample at cycle t (FIFO empty, FSM IDLE) → header pushed in t+1 → `DATAVALID=1` with the header on `DATAUP` in t+2. The packet occupies consecutive pushes t+1..t+2+W.
- Throughput: one word pushed and one popped per cycle, sustained.
- A command and a `PROBE_VALID` in the same cycle: the capture uses the enable state from before the command.
- One-shot armed and sample in the same cycle: no capture.

## Test plan
- Reset defaults: hold `URST=0` 2 cycles → `DATAVALID=0`, `DATAUP=0`, `DELAY=0`. A `PROBE_VALID` pulse with no enable → no output.
- Single packet: `WIDTH=40`, enable ch1 (`PROBEBASE=8`), 3 `CTIMER` ticks, sample `40'hAB_1234_5678`, `ACK` tied high → words `0009_0002`, `00000003`, `12345678`, `000000AB`. Header appears 2 cycles after the sample.
- One-shot: arm ch0, two samples 5 cycles apart → only the first packet appears; ch0 ends disabled.
- Overflow and backpressure: `DEPTH=4`, `ACK=0`, enable ch0 and send 3 samples → `DELAY=1` while FIFO full and ch0 pending. Release `ACK` → second header carries bit15=1, and the third sample is dropped.
- Round-robin: ch0–ch3 valid in the same cycle → headers in order 0,1,2,3. Repeat with pointer after ch1 → order 2,3,0,1.
- Timestamp: opcode 5 mid-count, then wrap from `FFFFFFFF` to 0; out-of-range probe number 0x00FF → ignored.
